// File: rtl/seven_seg_mux.sv
// Time-multiplexed hex 7-segment driver with frame-synchronous loading, leading-zero
// suppression, per-digit blanking, PWM brightness, one-cycle dead time and a frame strobe.
module seven_seg_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 262144,
    parameter int BRIGHT_W    = 4,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [4*NUM_DIGITS-1:0]   i_digits,
    input  logic [NUM_DIGITS-1:0]     i_dp,
    input  logic                      i_load,
    input  logic [NUM_DIGITS-1:0]     i_blank_mask,
    input  logic                      i_lz_suppress,
    input  logic [BRIGHT_W-1:0]       i_brightness,
    output logic [NUM_DIGITS-1:0]     o_anode,
    output logic [6:0]                o_seg,
    output logic                      o_dp,
    output logic                      o_frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_slot_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_dig;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_flag;
    logic [4*NUM_DIGITS-1:0] r_shd_dig;
    logic [NUM_DIGITS-1:0]   r_shd_dp;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_seg;
    logic                    r_dp;

    logic                    w_slot_wrap;
    logic                    w_frame_end;
    logic [3:0]              w_dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_zero_run;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [3:0]              w_cur_dig;
    logic                    w_cur_supp;
    logic                    w_cur_dp;
    logic                    w_cur_blank;
    logic [6:0]              w_glyph;
    logic                    w_gate;
    logic [NUM_DIGITS-1:0]   w_anode_act;

    assign w_slot_wrap = (r_slot_cnt == CNT_LAST);
    assign w_frame_end = w_slot_wrap && (r_idx == IDX_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot_cnt <= '0;
            r_idx      <= '0;
        end else if (w_slot_wrap) begin
            r_slot_cnt <= '0;
            r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_slot_cnt <= r_slot_cnt + CNT_W'(1);
        end
    end

    // A load landing on the frame boundary bypasses the pending stage entirely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_dig  <= '0;
            r_pend_dp   <= '0;
            r_pend_flag <= 1'b0;
            r_shd_dig   <= '0;
            r_shd_dp    <= '0;
        end else if (w_frame_end) begin
            r_pend_flag <= 1'b0;
            if (i_load) begin
                r_pend_dig <= i_digits;
                r_pend_dp  <= i_dp;
                r_shd_dig  <= i_digits;
                r_shd_dp   <= i_dp;
            end else if (r_pend_flag) begin
                r_shd_dig <= r_pend_dig;
                r_shd_dp  <= r_pend_dp;
            end
        end else if (i_load) begin
            r_pend_dig  <= i_digits;
            r_pend_dp   <= i_dp;
            r_pend_flag <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_dig[gi]      = r_shd_dig[4*gi +: 4];
            assign w_zero_run[gi] = (r_shd_dig[4*NUM_DIGITS-1:4*gi] == '0);
            assign w_sel[gi]      = (r_idx == IDX_W'(gi));
            if (gi == 0) begin : g_lsd
                assign w_supp[gi] = 1'b0;
            end else begin : g_upper
                assign w_supp[gi] = i_lz_suppress && w_zero_run[gi];
            end
        end
    endgenerate

    always_comb begin
        w_cur_dig   = 4'h0;
        w_cur_supp  = 1'b0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
                w_cur_dig   = w_dig[i];
                w_cur_supp  = w_supp[i];
                w_cur_dp    = r_shd_dp[i];
                w_cur_blank = i_blank_mask[i];
            end
        end
    end

    // Segment order {a,b,c,d,e,f,g}, active-high.
    always_comb begin
        w_glyph = 7'h00;
        case (w_cur_dig)
            4'h0: w_glyph = 7'h7E;
            4'h1: w_glyph = 7'h30;
            4'h2: w_glyph = 7'h6D;
            4'h3: w_glyph = 7'h79;
            4'h4: w_glyph = 7'h33;
            4'h5: w_glyph = 7'h5B;
            4'h6: w_glyph = 7'h5F;
            4'h7: w_glyph = 7'h70;
            4'h8: w_glyph = 7'h7F;
            4'h9: w_glyph = 7'h7B;
            4'hA: w_glyph = 7'h77;
            4'hB: w_glyph = 7'h1F;
            4'hC: w_glyph = 7'h4E;
            4'hD: w_glyph = 7'h3D;
            4'hE: w_glyph = 7'h4F;
            4'hF: w_glyph = 7'h47;
            default: w_glyph = 7'h00;
        endcase
    end

    // Phase 0 of every slot is dead time, so the top brightness code is one cycle short of full.
    assign w_gate      = (r_slot_cnt != '0) &&
                         (r_slot_cnt[BRIGHT_W-1:0] <= i_brightness) && !w_cur_blank;
    assign w_anode_act = w_gate ? w_sel : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_anode <= {NUM_DIGITS{ACTIVE_LOW}};
            r_seg   <= {7{ACTIVE_LOW}};
            r_dp    <= ACTIVE_LOW;
        end else begin
            r_anode <= w_anode_act ^ {NUM_DIGITS{ACTIVE_LOW}};
            r_seg   <= (w_cur_supp ? 7'h00 : w_glyph) ^ {7{ACTIVE_LOW}};
            r_dp    <= w_cur_dp ^ ACTIVE_LOW;
        end
    end

    assign o_anode      = r_anode;
    assign o_seg        = r_seg;
    assign o_dp         = r_dp;
    assign o_frame_done = w_frame_end;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux: table of display frames plus hand-written
// sequences for mid-frame loads, boundary-coincident load, frame period and async reset.
module tb_seven_seg_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        load;
    logic [3:0]  blank;
    logic        lz;
    logic [3:0]  bright;
    logic [3:0]  o_anode;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic        o_frame_done;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];
    int         exp_cnt [4];
    int         act_cnt [4];

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic [3:0]  bright;
        logic [27:0] seg;   // {d3,d2,d1,d0} active-low glyphs
        logic [3:0]  dpx;   // expected dp_out level per digit
        logic [15:0] cnt;   // {c3,c2,c1,c0} active clocks per slot
    } vec_t;

    vec_t vecs [9];

    seven_seg_mux #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(16),
        .BRIGHT_W   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_digits     (digits),
        .i_dp         (dp),
        .i_load       (load),
        .i_blank_mask (blank),
        .i_lz_suppress(lz),
        .i_brightness (bright),
        .o_anode      (o_anode),
        .o_seg        (o_seg),
        .o_dp         (o_dp),
        .o_frame_done (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_exp(input vec_t v);
        for (int d = 0; d < 4; d++) begin
            exp_seg[d] = v.seg[7*d +: 7];
            exp_dp[d]  = v.dpx[d];
            exp_cnt[d] = int'(v.cnt[4*d +: 4]);
        end
    endtask

    task automatic sample_one(input bit chk, input int exp_idx);
        int nact;
        int d;
        @(negedge clk);
        if (chk) begin
            nact = 0;
            d    = 0;
            for (int i = 0; i < 4; i++) begin
                if (o_anode[i] == 1'b0) begin
                    nact++;
                    d = i;
                end
            end
            checks++;
            if (nact > 1 || (nact == 1 && d != exp_idx)) begin
                errors++;
                $display("FAIL anode_slot anode=%b required_idx=%0d", o_anode, exp_idx);
            end else if (nact == 1) begin
                act_cnt[d]++;
                checks++;
                if (o_seg !== exp_seg[d] || o_dp !== exp_dp[d]) begin
                    errors++;
                    $display("FAIL seg_dp digit=%0d seg=%h dp=%b required seg=%h dp=%b",
                             d, o_seg, o_dp, exp_seg[d], exp_dp[d]);
                end
            end
        end
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (o_frame_done === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            errors++;
            $display("FAIL frame_done_timeout frame_done=%b required=1", o_frame_done);
        end
    endtask

    // 64 samples covering output of states 0..63 of one frame; optional mid-frame loads.
    task automatic check_window(input int load_at, input string tag);
        for (int d = 0; d < 4; d++) act_cnt[d] = 0;
        for (int j = 0; j < 64; j++) begin
            sample_one(1'b1, j / 16);
            checks++;
            if (o_frame_done !== (j == 62)) begin
                errors++;
                $display("FAIL frame_done_pos j=%0d frame_done=%b required=%b",
                         j, o_frame_done, (j == 62));
            end
            if (load_at >= 0) begin
                if (j == load_at) begin
                    digits = 16'h0000;
                    load   = 1'b1;
                end else if (j == load_at + 1) begin
                    load = 1'b0;
                end else if (j == load_at + 3) begin
                    digits = 16'h5678;
                    load   = 1'b1;
                end else if (j == load_at + 4) begin
                    load = 1'b0;
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (act_cnt[d] != exp_cnt[d]) begin
                errors++;
                $display("FAIL active_count %s digit=%0d got=%0d required=%0d",
                         tag, d, act_cnt[d], exp_cnt[d]);
            end
        end
        $display("frame %s checked: counts %0d %0d %0d %0d", tag,
                 act_cnt[3], act_cnt[2], act_cnt[1], act_cnt[0]);
    endtask

    task automatic check_frame(input string tag);
        bit ok;
        wait_frame(ok);
        if (ok) begin
            sample_one(1'b0, 0);
            check_window(-1, tag);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        blank  = v.blank;
        lz     = v.lz;
        bright = v.bright;
        digits = v.digits;
        dp     = v.dp;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        set_exp(v);
    endtask

    initial begin
        bit ok;
        int n;
        vec_t v;

        vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 4'hF,
                    {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1111, 16'hFFFF};
        vecs[1] = '{16'h0070, 4'b0000, 4'b0000, 1'b1, 4'hF,
                    {7'h7F, 7'h7F, 7'h0F, 7'h01}, 4'b1111, 16'hFFFF};
        vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 4'hF,
                    {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'b1111, 16'hFFFF};
        vecs[3] = '{16'hEF9A, 4'b0000, 4'b0000, 1'b0, 4'h3,
                    {7'h30, 7'h38, 7'h04, 7'h08}, 4'b1111, 16'h3333};
        vecs[4] = '{16'hBCD6, 4'b0000, 4'b0000, 1'b0, 4'h7,
                    {7'h60, 7'h31, 7'h42, 7'h20}, 4'b1111, 16'h7777};
        vecs[5] = '{16'h5678, 4'b0000, 4'b0000, 1'b0, 4'h0,
                    {7'h24, 7'h20, 7'h0F, 7'h00}, 4'b1111, 16'h0000};
        vecs[6] = '{16'h1234, 4'b0010, 4'b0101, 1'b0, 4'hF,
                    {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1101, 16'hF0F0};
        vecs[7] = '{16'h0005, 4'b1000, 4'b0000, 1'b1, 4'hF,
                    {7'h7F, 7'h7F, 7'h7F, 7'h24}, 4'b0111, 16'hFFFF};
        vecs[8] = '{16'h0105, 4'b0000, 4'b0000, 1'b1, 4'hF,
                    {7'h7F, 7'h4F, 7'h01, 7'h24}, 4'b1111, 16'hFFFF};

        rst_n  = 1'b0;
        digits = '0;
        dp     = '0;
        load   = 1'b0;
        blank  = '0;
        lz     = 1'b0;
        bright = 4'hF;

        repeat (3) @(negedge clk);
        checks++;
        if (o_anode !== 4'hF || o_seg !== 7'h7F || o_dp !== 1'b1 || o_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state anode=%b seg=%h dp=%b fd=%b required 1111/7f/1/0",
                     o_anode, o_seg, o_dp, o_frame_done);
        end
        $display("reset state checked");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            apply_vec(v);
            check_frame($sformatf("vec%0d_%h", i, v.digits));
        end

        // Loads mid-frame must not disturb the frame being shown; last load wins.
        apply_vec(vecs[0]);
        check_frame("pre_midload_1234");
        wait_frame(ok);
        if (ok) begin
            sample_one(1'b0, 0);
            check_window(10, "midload_still_1234");
            v = '{16'h5678, 4'b0000, 4'b0000, 1'b0, 4'hF,
                  {7'h24, 7'h20, 7'h0F, 7'h00}, 4'b1111, 16'hFFFF};
            set_exp(v);
            check_frame("after_midload_5678");
        end

        // Load coincident with the boundary goes straight to the display.
        wait_frame(ok);
        if (ok) begin
            digits = 16'h9876;
            load   = 1'b1;
            sample_one(1'b0, 0);
            load   = 1'b0;
            v = '{16'h9876, 4'b0000, 4'b0000, 1'b0, 4'hF,
                  {7'h04, 7'h00, 7'h0F, 7'h20}, 4'b1111, 16'hFFFF};
            set_exp(v);
            check_window(-1, "boundary_load_9876");
            check_window(-1, "boundary_load_9876_next");
        end

        // Frame period.
        wait_frame(ok);
        if (ok) begin
            n = 0;
            ok = 1'b0;
            while (!ok && n < 200) begin
                @(negedge clk);
                n++;
                if (o_frame_done === 1'b1) ok = 1'b1;
            end
            checks++;
            if (n != 64) begin
                errors++;
                $display("FAIL frame_period got=%0d required=64", n);
            end
            $display("frame period measured %0d clocks", n);
        end

        // Async reset at idx 2, slot_cnt 9.
        wait_frame(ok);
        if (ok) begin
            repeat (42) @(negedge clk);
            checks++;
            if (o_anode !== 4'b1011) begin
                errors++;
                $display("FAIL pre_reset_anode got=%b required=1011", o_anode);
            end
            #2;
            rst_n = 1'b0;
            #1;
            checks++;
            if (o_anode !== 4'hF || o_seg !== 7'h7F || o_dp !== 1'b1 || o_frame_done !== 1'b0) begin
                errors++;
                $display("FAIL async_reset anode=%b seg=%h dp=%b fd=%b required 1111/7f/1/0",
                         o_anode, o_seg, o_dp, o_frame_done);
            end
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            checks++;
            if (o_anode !== 4'hF) begin
                errors++;
                $display("FAIL post_reset_dead got=%b required=1111", o_anode);
            end
            @(negedge clk);
            checks++;
            if (o_anode !== 4'b1110) begin
                errors++;
                $display("FAIL post_reset_idx0 got=%b required=1110", o_anode);
            end
            n = 2;
            ok = 1'b0;
            while (!ok && n < 200) begin
                @(negedge clk);
                n++;
                if (o_frame_done === 1'b1) ok = 1'b1;
            end
            checks++;
            if (n != 63) begin
                errors++;
                $display("FAIL post_reset_first_frame got=%0d required=63", n);
            end
            $display("async reset sequence checked, first frame_done after %0d clocks", n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
